// File: rtl/sysa_drain.sv
// Output collector for the systolic array: de-skews the bottom-row partial sums into aligned rows,
// buffers them in a show-ahead FIFO and streams them out with a per-tile last tag. Option: DRAIN_RELU_EN.
module sysa_drain #(
  parameter int unsigned COLS  = 4,
  parameter int unsigned DW    = 16,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [COLS*DW-1:0]         col_in,
  output logic [COLS*DW-1:0]         out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       busy,
  output logic                       overflow
);

  localparam int unsigned RW = COLS * DW;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned VD = COLS - 1;

  logic [VD-1:0] vld_sr;
  logic [VD-1:0] vld_n;
  logic [RW-1:0] aligned;
  logic [RW-1:0] wdata;

  logic [RW:0]   mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [CW-1:0] row_cnt, row_cnt_n;
  logic [LW-1:0] lvl_cur, lvl_n;
  logic          push, pop, full, wr_en, overflow_n, busy_n, last_tag;

  // Lane c waits COLS-1-c cycles so every lane of a row lines up with the last column.
  for (genvar c = 0; c < int'(VD); c++) begin : g_lane
    localparam int unsigned D = VD - c;
    logic [DW-1:0] dly [D];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(D); i++) dly[i] <= '0;
      end else begin
        dly[0] <= col_in[c*DW +: DW];
        for (int i = 1; i < int'(D); i++) dly[i] <= dly[i-1];
      end
    end

    assign aligned[c*DW +: DW] = dly[D-1];
  end
  assign aligned[VD*DW +: DW] = col_in[VD*DW +: DW];

  // Write-side lane conditioning.
  always_comb begin
    wdata = aligned;
`ifdef DRAIN_RELU_EN
    for (int c = 0; c < int'(COLS); c++) begin
      if (aligned[c*DW + DW - 1]) wdata[c*DW +: DW] = '0;
    end
`endif
  end

  // Next-state: de-skew valids, FIFO pointers, row counter and flags.
  always_comb begin
    lvl_cur    = LW'(wr_ptr - rd_ptr);
    full       = (lvl_cur == LW'(DEPTH));
    push       = vld_sr[VD-1];
    pop        = out_valid & out_ready;
    wr_en      = push & (~full | pop);
    last_tag   = (row_cnt == CW'(ROWS - 1));
    vld_n      = VD'({vld_sr, in_valid});
    wr_ptr_n   = wr_ptr + LW'(wr_en);
    rd_ptr_n   = rd_ptr + LW'(pop);
    row_cnt_n  = row_cnt;
    overflow_n = overflow | (push & full & ~pop);
    if (push) row_cnt_n = last_tag ? '0 : CW'(row_cnt + CW'(1));
    if (start) begin
      wr_en      = 1'b0;
      vld_n      = '0;
      wr_ptr_n   = '0;
      rd_ptr_n   = '0;
      row_cnt_n  = '0;
      overflow_n = 1'b0;
    end
    lvl_n  = LW'(wr_ptr_n - rd_ptr_n);
    busy_n = (|vld_n) | (lvl_n != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_sr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      row_cnt   <= '0;
      overflow  <= 1'b0;
      level     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      vld_sr    <= vld_n;
      wr_ptr    <= wr_ptr_n;
      rd_ptr    <= rd_ptr_n;
      row_cnt   <= row_cnt_n;
      overflow  <= overflow_n;
      level     <= lvl_n;
      out_valid <= (lvl_n != '0);
      busy      <= busy_n;
      if (wr_en) mem[wr_ptr[AW-1:0]] <= {last_tag, wdata};
    end
  end

  // Show-ahead head of the registered storage.
  assign out_data = mem[rd_ptr[AW-1:0]][RW-1:0];
  assign out_last = mem[rd_ptr[AW-1:0]][RW];

endmodule
